ps2_note_receiver: RTL and testbench

- Upstream stage of the VGA note display: receives PS/2 keyboard frames and drives the 8-bit `scan` code that `vga_controller` consumes.
- Synchronises and filters the PS/2 lines, deserialises and checks 11-bit frames, and resolves make/break (F0) and extended (E0) prefixes into a held-key code.
- While no key is held, `scan` is 8'h00, which the display treats as "no note".

---
 rtl/ps2_note_receiver.sv | 189 ++++++++++++++++++
 tb/tb_ps2_note_receiver.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_note_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, checks 11-bit frames,
// and resolves F0/E0 prefixes into the held-key scan code shown by the VGA note display.
module ps2_note_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan,
    output logic       key_down,
    output logic       code_strobe,
    output logic       frame_err
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           sample;

    state_t         state_q, state_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     sr_q, sr_d;
    logic           par_q, par_d;
    logic [TW-1:0]  to_q, to_d;
    logic           timeout;
    logic           bv_q, bv_d;
    logic           err_q, err_d;

    logic           brk_q, brk_d, ext_q, ext_d;
    logic [7:0]     scan_q, scan_d;
    logic           kd_q, kd_d;
    logic           stb_q, stb_d;

    // Synchronisers idle high, matching an idle PS/2 bus.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            fcnt_d = '0;
            filt_d = clk_s2_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign sample  = filt_q && !clk_s2_q && (fcnt_q == FCW'(FILTER_LEN - 1));
    assign timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
            bv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            to_q    <= to_d;
            bv_q    <= bv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        par_d   = par_q;
        to_d    = (state_q == IDLE) ? '0 : to_q + 1'b1;
        bv_d    = 1'b0;
        err_d   = 1'b0;
        // Timeout wins over any sample event landing on the same cycle.
        if (timeout) begin
            state_d = IDLE;
            bcnt_d  = '0;
            sr_d    = '0;
            to_d    = '0;
            err_d   = 1'b1;
        end else if (sample) begin
            to_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
                DATA: begin
                    sr_d   = {dat_s2_q, sr_q[7:1]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    if ((^sr_q ^ par_q) && dat_s2_q) bv_d = 1'b1;
                    else                              err_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            brk_q  <= 1'b0;
            ext_q  <= 1'b0;
            scan_q <= 8'h00;
            kd_q   <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            brk_q  <= brk_d;
            ext_q  <= ext_d;
            scan_q <= scan_d;
            kd_q   <= kd_d;
            stb_q  <= stb_d;
        end
    end

    // sr_q still holds the completed byte while bv_q is high.
    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        scan_d = scan_q;
        kd_d   = kd_q;
        stb_d  = 1'b0;
        if (bv_q) begin
            if (sr_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (sr_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                if (sr_q == scan_q) begin
                    scan_d = 8'h00;
                    kd_d   = 1'b0;
                    stb_d  = 1'b1;
                end
            end else begin
                scan_d = sr_q;
                kd_d   = 1'b1;
                stb_d  = 1'b1;
            end
        end
    end

    assign scan        = scan_q;
    assign key_down    = kd_q;
    assign code_strobe = stb_q;
    assign frame_err   = err_q;
endmodule

// File: tb/tb_ps2_note_receiver.sv
// Directed bench for ps2_note_receiver: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_note_receiver;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HALF        = 50;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [7:0] scan;
    logic       key_down, code_strobe, frame_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_stb  = 0;
    int n_err  = 0;
    int lat    = 0;
    int s0, e0;

    ps2_note_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan       (scan),
        .key_down   (key_down),
        .code_strobe(code_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) begin
        if (code_strobe) n_stb <= n_stb + 1;
        if (frame_err)   n_err <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits bits of a frame; records strobe latency on the stop-bit edge.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_100MHz);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk_100MHz);
            ps2_clk = 1'b0;
            if (i == 10) begin
                lat = 0;
                for (int k = 1; k <= HALF; k++) begin
                    @(posedge clk_100MHz);
                    #1;
                    if (code_strobe && lat == 0) lat = k;
                end
                @(negedge clk_100MHz);
            end else begin
                repeat (HALF) @(negedge clk_100MHz);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk_100MHz);
        ps2_data = 1'b1;
        repeat (4 * HALF) @(negedge clk_100MHz);
    endtask

    initial begin
        repeat (5) @(negedge clk_100MHz);
        check("rst_scan", scan, 8'h00);
        check("rst_kd", key_down, 1'b0);
        check("rst_stb", code_strobe, 1'b0);
        check("rst_err", frame_err, 1'b0);
        reset = 1'b1;
        repeat (3000) @(negedge clk_100MHz);
        check("idle_scan", scan, 8'h00);
        check("idle_kd", key_down, 1'b0);
        check("idle_stb", n_stb, 0);
        check("idle_err", n_err, 0);

        // 2 sync stages + FILTER_LEN filter samples, then 2 cycles to the strobe.
        send_frame(8'h1C, 1'b0, 11);
        check("lat_1c", lat, FILTER_LEN + 3);
        check("scan_1c", scan, 8'h1C);
        check("kd_1c", key_down, 1'b1);
        check("stb_1c", n_stb, 1);

        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        check("rel_1c", scan, 8'h00);
        check("rel_1c_kd", key_down, 1'b0);

        s0 = n_stb;
        send_frame(8'h23, 1'b0, 11);
        check("make_23", scan, 8'h23);
        send_frame(8'hF0, 1'b0, 11);
        check("f0_hold", scan, 8'h23);
        check("f0_nostb", n_stb, s0 + 1);
        send_frame(8'h23, 1'b0, 11);
        check("brk_23", scan, 8'h00);
        check("brk_23_stb", n_stb, s0 + 2);

        send_frame(8'h2D, 1'b0, 11);
        s0 = n_stb;
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h3A, 1'b0, 11);
        check("brk_other", scan, 8'h2D);
        check("brk_other_kd", key_down, 1'b1);
        check("brk_other_stb", n_stb, s0);

        e0 = n_err; s0 = n_stb;
        send_frame(8'h2B, 1'b1, 11);
        check("par_err", n_err, e0 + 1);
        check("par_scan", scan, 8'h2D);
        check("par_stb", n_stb, s0);
        send_frame(8'h2B, 1'b0, 11);
        check("good_2b", scan, 8'h2B);

        e0 = n_err;
        send_frame(8'h4B, 1'b0, 4);
        check("to_early", n_err, e0);
        repeat (TIMEOUT_CYC + 100) @(negedge clk_100MHz);
        check("to_err", n_err, e0 + 1);
        send_frame(8'h4B, 1'b0, 11);
        check("after_to", scan, 8'h4B);
        check("after_to_kd", key_down, 1'b1);

        s0 = n_stb;
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        check("ext_scan", scan, 8'h4B);
        check("ext_stb", n_stb, s0);
        send_frame(8'h76, 1'b0, 11);
        check("esc_make", scan, 8'h76);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h76, 1'b0, 11);
        check("esc_brk", scan, 8'h00);

        send_frame(8'h5A, 1'b0, 11);
        check("make_5a", scan, 8'h5A);
        send_frame(8'h1C, 1'b0, 6);
        reset = 1'b0;
        #1;
        check("midrst_scan", scan, 8'h00);
        check("midrst_kd", key_down, 1'b0);
        check("midrst_stb", code_strobe, 1'b0);
        check("midrst_err", frame_err, 1'b0);
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b1;
        repeat (20) @(negedge clk_100MHz);
        send_frame(8'h1C, 1'b0, 11);
        check("post_rst_1c", scan, 8'h1C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
